// File: rtl/mmu_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mmu_seq : command sequencer and result reader for the 4x4 systolic MMU  |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module mmu_seq #(
    parameter int ACLEN        = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int KLEN_W       = 16,
    parameter int FLUSH_CYCLES = 6
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   start_i,
    input  logic [KLEN_W-1:0]                      k_len_i,
    input  logic                                   mode_i,
    output logic                                   busy_o,
    output logic                                   done_o,
    input  logic                                   op_valid_i,
    output logic                                   op_ready_o,
    input  logic [4*DATA_WIDTH-1:0]                op_data_i,
    input  logic [4*DATA_WIDTH-1:0]                op_weight_i,
    output logic                                   mmu_cmd_valid_o,
    output logic [ACLEN:0]                         mmu_cmd_o,
    output logic [DATA_WIDTH-1:0]                  mmu_param_1_o,
    output logic [DATA_WIDTH-1:0]                  mmu_param_2_o,
    output logic [4*DATA_WIDTH-1:0]                mmu_data_o,
    output logic [4*DATA_WIDTH-1:0]                mmu_weight_o,
    input  logic                                   mmu_busy_i,
    input  logic [3:0][4*DATA_WIDTH-1:0]           mmu_rdata_i,
    output logic                                   res_valid_o,
    input  logic                                   res_ready_i,
    output logic [4*DATA_WIDTH-1:0]                res_data_o,
    output logic [1:0]                             res_idx_o,
    output logic                                   res_last_o
);

    localparam int ROW_W   = 4 * DATA_WIDTH;
    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [ACLEN:0] CMD_RESET    = (ACLEN+1)'(0);
    localparam logic [ACLEN:0] CMD_TRIGGER  = (ACLEN+1)'(1);
    localparam logic [ACLEN:0] CMD_CONV     = (ACLEN+1)'(5);
    localparam logic [ACLEN:0] CMD_FIX_MAC  = (ACLEN+1)'(6);
    localparam logic [ACLEN:0] CMD_IDLE     = (ACLEN+1)'(7);

    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RST   = 3'd1,
        ST_MODE  = 3'd2,
        ST_FEED  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_WAIT  = 3'd5,
        ST_CAPT  = 3'd6,
        ST_DRAIN = 3'd7
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [KLEN_W-1:0]         k_len_q;
    logic                      mode_q;
    logic [KLEN_W-1:0]         beat_cnt;
    logic [FLUSH_W-1:0]        flush_cnt;
    logic [1:0]                drain_idx;
    logic [3:0][ROW_W-1:0]     rows;
    logic                      done_q;

    logic                      cmd_valid;
    logic [ACLEN:0]            cmd;
    logic                      pass_ops;
    logic                      op_ready;
    logic                      last_beat;
    logic                      last_flush;
    logic                      feed_hs;
    logic                      drain_hs;

    // The beat counter stops at K-1, so K = 2^KLEN_W - 1 never wraps.
    assign last_beat  = (beat_cnt == (k_len_q - KLEN_W'(1)));
    assign last_flush = (flush_cnt == FLUSH_LAST);
    assign feed_hs    = (state == ST_FEED) && op_valid_i;
    assign drain_hs   = (state == ST_DRAIN) && res_ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_valid = 1'b0;
        cmd       = CMD_IDLE;
        pass_ops  = 1'b0;
        op_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = ST_RST;
                end
            end
            ST_RST: begin
                cmd_valid = 1'b1;
                cmd       = CMD_RESET;
                state_nxt = ST_MODE;
            end
            ST_MODE: begin
                cmd_valid = 1'b1;
                cmd       = mode_q ? CMD_CONV : CMD_FIX_MAC;
                state_nxt = (k_len_q == '0) ? ST_WAIT : ST_FEED;
            end
            ST_FEED: begin
                // A missing operand stalls the array rather than inserting a bubble.
                op_ready  = 1'b1;
                cmd_valid = op_valid_i;
                cmd       = CMD_TRIGGER;
                pass_ops  = 1'b1;
                if (op_valid_i && last_beat) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                cmd_valid = 1'b1;
                cmd       = CMD_TRIGGER;
                if (last_flush) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!mmu_busy_i) begin
                    state_nxt = ST_CAPT;
                end
            end
            ST_CAPT: begin
                state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (res_ready_i && (drain_idx == 2'd3)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            k_len_q   <= '0;
            mode_q    <= 1'b0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            drain_idx <= 2'd0;
            rows      <= '0;
            done_q    <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && start_i) begin
                k_len_q <= k_len_i;
                mode_q  <= mode_i;
            end
            if (feed_hs) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + KLEN_W'(1);
            end
            if (state == ST_FLUSH) begin
                flush_cnt <= last_flush ? '0 : flush_cnt + FLUSH_W'(1);
            end
            if (state == ST_CAPT) begin
                rows <= mmu_rdata_i;
            end
            if (drain_hs) begin
                drain_idx <= drain_idx + 2'd1;
            end
            done_q <= drain_hs && (drain_idx == 2'd3);
        end
    end

    generate
        for (genvar n = 0; n < 4; n++) begin : g_lane
            assign mmu_data_o[n*DATA_WIDTH +: DATA_WIDTH] =
                pass_ops ? op_data_i[n*DATA_WIDTH +: DATA_WIDTH] : '0;
            assign mmu_weight_o[n*DATA_WIDTH +: DATA_WIDTH] =
                pass_ops ? op_weight_i[n*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    endgenerate

    assign busy_o          = (state != ST_IDLE);
    assign done_o          = done_q;
    assign op_ready_o      = op_ready;
    assign mmu_cmd_valid_o = cmd_valid;
    assign mmu_cmd_o       = cmd;
    assign mmu_param_1_o   = '0;
    assign mmu_param_2_o   = '0;

    assign res_valid_o = (state == ST_DRAIN);
    assign res_data_o  = res_valid_o ? rows[drain_idx] : '0;
    assign res_idx_o   = res_valid_o ? drain_idx : 2'd0;
    assign res_last_o  = res_valid_o && (drain_idx == 2'd3);

endmodule
`default_nettype wire

// File: tb/tb_mmu_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mmu_seq : directed, self-checking bench for mmu_seq                  |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module tb_mmu_seq;

    localparam int DW = 32;
    localparam int LW = 4 * DW;
    localparam int KW = 16;
    localparam int MAXJ = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_i, start_i, mode_i, busy_o, done_o;
    logic [KW-1:0]        k_len_i;
    logic                 op_valid_i, op_ready_o;
    logic [LW-1:0]        op_data_i, op_weight_i;
    logic                 mmu_cmd_valid_o;
    logic [4:0]           mmu_cmd_o;
    logic [DW-1:0]        mmu_param_1_o, mmu_param_2_o;
    logic [LW-1:0]        mmu_data_o, mmu_weight_o;
    logic                 mmu_busy_i;
    logic [3:0][LW-1:0]   mmu_rdata_i;
    logic                 res_valid_o, res_ready_i, res_last_o;
    logic [LW-1:0]        res_data_o;
    logic [1:0]           res_idx_o;

    mmu_seq #(.ACLEN(4), .DATA_WIDTH(DW), .KLEN_W(KW), .FLUSH_CYCLES(6)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .k_len_i(k_len_i), .mode_i(mode_i),
        .busy_o(busy_o), .done_o(done_o), .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
        .op_data_i(op_data_i), .op_weight_i(op_weight_i), .mmu_cmd_valid_o(mmu_cmd_valid_o),
        .mmu_cmd_o(mmu_cmd_o), .mmu_param_1_o(mmu_param_1_o), .mmu_param_2_o(mmu_param_2_o),
        .mmu_data_o(mmu_data_o), .mmu_weight_o(mmu_weight_o), .mmu_busy_i(mmu_busy_i),
        .mmu_rdata_i(mmu_rdata_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_data_o(res_data_o), .res_idx_o(res_idx_o), .res_last_o(res_last_o)
    );

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct { int cyc; logic [4:0] cmd; bit chk_lanes; logic [LW-1:0] data; logic [LW-1:0] weight; } cmd_t;
    typedef struct { int first; int accept; logic [1:0] idx; logic [LW-1:0] data; } beat_t;
    typedef struct { int lo; int hi; } rng_t;
    typedef struct { int cyc; int k; logic mode; } start_t;

    cmd_t   cmd_q[$];
    beat_t  beat_q[$];
    rng_t   stall_r[$], busy_r[$], ready_r[$], rst_r[$];
    start_t start_l[$];

    int j_t[MAXJ], j_feed_lo[MAXJ], j_feed_hi[MAXJ], j_stop[MAXJ], j_done[MAXJ];
    bit j_abort[MAXJ];
    int nj = 0;
    int o_done[MAXJ], o_trig[MAXJ], o_dtrig[MAXJ];
    logic [4:0] o_mode[MAXJ];
    logic [LW-1:0] j0_first_data = '0;
    bit j0_first_seen = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Stimulus as pure functions of the cycle number.
    function automatic bit valid_fn(input int n);
        foreach (stall_r[i]) if (n >= stall_r[i].lo && n < stall_r[i].hi) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit busy_fn(input int n);
        foreach (busy_r[i]) if (n >= busy_r[i].lo && n < busy_r[i].hi) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ready_fn(input int n);
        foreach (ready_r[i]) if (n >= ready_r[i].lo && n < ready_r[i].hi) return (n % 2) == 1;
        return 1'b1;
    endfunction

    function automatic bit rst_fn(input int n);
        if (n < 3) return 1'b0;
        foreach (rst_r[i]) if (n >= rst_r[i].lo && n < rst_r[i].hi) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [LW-1:0] ops(input int n, input bit wgt);
        logic [LW-1:0] v;
        for (int lane = 0; lane < 4; lane++) begin
            if (n >= 5 && n < 25) v[lane*DW +: DW] = 32'(lane + 1);
            else v[lane*DW +: DW] = (wgt ? 32'hB000_0000 : 32'hA000_0000) | 32'(n << 4) | 32'(lane);
        end
        return v;
    endfunction

    function automatic int job_of(input int n);
        int c = 0;
        for (int i = 0; i < nj; i++) if (j_t[i] <= n) c++;
        return c;
    endfunction

    function automatic logic [LW-1:0] rdata_row(input int n, input int r);
        logic [LW-1:0] v;
        for (int lane = 0; lane < 4; lane++) begin
            if (busy_fn(n)) v[lane*DW +: DW] = 32'hDEAD_0000 | 32'(n);
            else v[lane*DW +: DW] = {8'(job_of(n)), 8'(r), 8'(lane), 8'h5A};
        end
        return v;
    endfunction

    task automatic drive(input int n);
        rst_i      = rst_fn(n);
        start_i    = 1'b0;
        k_len_i    = 16'hFFFF;
        mode_i     = 1'b1;
        foreach (start_l[i]) if (start_l[i].cyc == n) begin
            start_i = 1'b1;
            k_len_i = KW'(start_l[i].k);
            mode_i  = start_l[i].mode;
        end
        op_valid_i  = valid_fn(n);
        op_data_i   = ops(n, 1'b0);
        op_weight_i = ops(n, 1'b1);
        mmu_busy_i  = busy_fn(n);
        for (int r = 0; r < 4; r++) mmu_rdata_i[r] = rdata_row(n, r);
        res_ready_i = ready_fn(n);
    endtask

    initial begin
        drive(0);
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            drive(cyc);
        end
    end

    task automatic push_cmd(input int c, input logic [4:0] code, input bit lanes,
                            input logic [LW-1:0] d, input logic [LW-1:0] w, input int stop);
        cmd_t e;
        if (c >= stop) return;
        e.cyc = c; e.cmd = code; e.chk_lanes = lanes; e.data = d; e.weight = w;
        cmd_q.push_back(e);
    endtask

    // Job model: derives every command/result cycle from the handshake and timing rules.
    task automatic plan_job(input int t, input int k, input logic mode, input int abort_at, output int done);
        int j, c, stop, w, d;
        start_t s;
        beat_t b;
        j = nj;
        nj++;
        s.cyc = t; s.k = k; s.mode = mode;
        start_l.push_back(s);
        j_t[j] = t;
        stop = (abort_at > 0) ? abort_at : 32'h3FFF_FFFF;
        push_cmd(t + 1, 5'd0, 1'b0, '0, '0, stop);
        push_cmd(t + 2, mode ? 5'd5 : 5'd6, 1'b0, '0, '0, stop);
        c = t + 3;
        j_feed_lo[j] = c;
        for (int i = 0; i < k; i++) begin
            while (!valid_fn(c)) c++;
            push_cmd(c, 5'd1, 1'b1, ops(c, 1'b0), ops(c, 1'b1), stop);
            c++;
        end
        j_feed_hi[j] = c - 1;
        if (k > 0) begin
            for (int i = 0; i < 6; i++) push_cmd(c + i, 5'd1, 1'b1, '0, '0, stop);
            c += 6;
        end
        w = c;
        while (busy_fn(w)) w++;
        d = w + 2;
        for (int r = 0; r < 4; r++) begin
            b.first = d;
            while (!ready_fn(d)) d++;
            b.accept = d; b.idx = 2'(r); b.data = rdata_row(w + 1, r);
            if (d < stop) beat_q.push_back(b);
            d++;
        end
        done = d;
        j_abort[j] = (abort_at > 0);
        j_done[j]  = (abort_at > 0) ? -1 : d;
        j_stop[j]  = (abort_at > 0) ? abort_at : d;
    endtask

    task automatic check_cycle(input int n);
        bit in_job, done_exp, feed;
        int jc;
        cmd_t e;
        in_job = 0; done_exp = 0; feed = 0; jc = -1;
        for (int i = 0; i < nj; i++) begin
            if (n >= j_t[i] + 1 && n < j_stop[i]) begin
                in_job = 1; jc = i;
                if (n >= j_feed_lo[i] && n <= j_feed_hi[i]) feed = 1;
            end
            if (!j_abort[i] && j_done[i] == n) done_exp = 1;
        end
        chk("busy", busy_o, in_job);
        chk("done", done_o, done_exp);
        chk("op_ready", op_ready_o, feed);
        chk("param1", mmu_param_1_o, '0);
        chk("param2", mmu_param_2_o, '0);
        if (cmd_q.size() > 0 && cmd_q[0].cyc == n) begin
            e = cmd_q.pop_front();
            chk("cmd_valid", mmu_cmd_valid_o, 1'b1);
            chk("cmd", mmu_cmd_o, e.cmd);
            if (e.chk_lanes) begin
                chk("cmd_data", mmu_data_o, e.data);
                chk("cmd_weight", mmu_weight_o, e.weight);
            end
        end else begin
            chk("no_cmd_valid", mmu_cmd_valid_o, 1'b0);
            if (!feed) begin
                chk("idle_cmd", mmu_cmd_o, 5'd7);
                chk("idle_data", mmu_data_o, '0);
                chk("idle_weight", mmu_weight_o, '0);
            end
        end
        if (beat_q.size() > 0 && n >= beat_q[0].first && n <= beat_q[0].accept) begin
            chk("res_valid", res_valid_o, 1'b1);
            chk("res_idx", res_idx_o, beat_q[0].idx);
            chk("res_last", res_last_o, beat_q[0].idx == 2'd3);
            chk("res_data", res_data_o, beat_q[0].data);
            if (n == beat_q[0].accept) void'(beat_q.pop_front());
        end else begin
            chk("res_valid_low", res_valid_o, 1'b0);
        end
        if (!rst_i) begin
            chk("rst_res_data", res_data_o, '0);
            chk("rst_res_idx", res_idx_o, 2'd0);
            chk("rst_res_last", res_last_o, 1'b0);
        end
        if (jc >= 0 && mmu_cmd_valid_o && mmu_cmd_o == 5'd1) begin
            o_trig[jc]++;
            if (feed) o_dtrig[jc]++;
            if (jc == 0 && !j0_first_seen) begin
                j0_first_seen = 1;
                j0_first_data = mmu_data_o;
            end
        end
        if (jc >= 0 && mmu_cmd_valid_o && n == j_t[jc] + 2) o_mode[jc] = mmu_cmd_o;
        if (done_o) begin
            for (int i = 0; i < nj; i++) if (j_t[i] < n && n <= j_stop[i]) o_done[i] = n;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check_cycle(cyc);
        end
    end

    initial begin
        int d0, d1, d2, d3, d4, d5, d6;
        start_t s;
        rng_t rg;
        for (int i = 0; i < MAXJ; i++) begin
            o_done[i] = -1; o_trig[i] = 0; o_dtrig[i] = 0; o_mode[i] = 5'd0;
        end
        // K=4 FIX_MAC, constant lanes 1..4; a start during the job must be ignored.
        plan_job(5, 4, 1'b0, 0, d0);
        s.cyc = 11; s.k = 3; s.mode = 1'b1;
        start_l.push_back(s);
        // K=3 CONV, started in the done cycle, 2nd beat stalled 2 cycles.
        rg.lo = 28; rg.hi = 30; stall_r.push_back(rg);
        plan_job(d0, 3, 1'b1, 0, d1);
        // K=0.
        plan_job(50, 0, 1'b0, 0, d2);
        // K=2 with busy held 5 cycles past the flush.
        rg.lo = 65; rg.hi = 78; busy_r.push_back(rg);
        plan_job(62, 2, 1'b1, 0, d3);
        // K=1 with res_ready toggling.
        rg.lo = 90; rg.hi = 130; ready_r.push_back(rg);
        plan_job(90, 1, 1'b0, 0, d4);
        // K=8 aborted by reset on beat 2, then a fresh job.
        rg.lo = 119; rg.hi = 121; rst_r.push_back(rg);
        plan_job(115, 8, 1'b0, 119, d5);
        plan_job(125, 5, 1'b1, 0, d6);

        while (cyc < d6 + 4 && cyc < 2000) @(negedge clk);
        #2;
        chk("j0_done_latency", o_done[0] - 5, 19);
        chk("j0_trig_count", o_trig[0], 10);
        chk("j0_mode_cmd", o_mode[0], 5'd6);
        chk("j0_first_lanes", j0_first_data, 128'h00000004_00000003_00000002_00000001);
        chk("j1_done_latency", o_done[1] - 24, 20);
        chk("j1_data_trigs", o_dtrig[1], 3);
        chk("j1_mode_cmd", o_mode[1], 5'd5);
        chk("j2_trig_count", o_trig[2], 0);
        chk("j2_done_latency", o_done[2] - 50, 9);
        chk("j3_done_latency", o_done[3] - 62, 22);
        chk("j4_done_latency", o_done[4] - 90, 20);
        chk("j5_no_done", o_done[5], -1);
        chk("j6_done_latency", o_done[6] - 125, 20);
        chk("cmds_all_seen", cmd_q.size(), 0);
        chk("beats_all_seen", beat_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
